// File: rtl/player_position.sv
// Purpose : horizontal position counter, position/motion registers and shadow latch for one player sprite.
// Latency : strobe, data, width and direction update one clk after the pixel_tick that matches pos.
// Backpr. : none; the block accepts every line_start, pixel_tick and register write on the clk it arrives.
//
// Ports:
//   clk, reset_n      - system clock, asynchronous active-low reset
//   line_start        - start of visible line, clears the pixel counter
//   pixel_tick        - one enable per colour clock, advances the pixel counter
//   reg_write/addr/data - CPU register write (GRP, REFP, NUSIZ, VDEL, HMP, RESP, HMOVE, HMCLR)
//   grp_other_write   - other player's GRP written; copies grp_new into grp_old
//   strobe            - one-clk start pulse to the serializer
//   data/width/direction - pattern, stretch code and bit order latched at each strobe
module player_position (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_start,
  input  logic       pixel_tick,
  input  logic       reg_write,
  input  logic [2:0] reg_addr,
  input  logic [7:0] reg_data,
  input  logic       grp_other_write,
  output logic       strobe,
  output logic [7:0] data,
  output logic [1:0] width,
  output logic       direction
);

  localparam logic [2:0] A_GRP   = 3'd0;
  localparam logic [2:0] A_REFP  = 3'd1;
  localparam logic [2:0] A_NUSIZ = 3'd2;
  localparam logic [2:0] A_VDEL  = 3'd3;
  localparam logic [2:0] A_HMP   = 3'd4;
  localparam logic [2:0] A_RESP  = 3'd5;
  localparam logic [2:0] A_HMOVE = 3'd6;
  localparam logic [2:0] A_HMCLR = 3'd7;

  localparam logic [7:0] LAST_PIXEL = 8'd159;

  logic [7:0] counter;
  logic [7:0] pos;
  logic [3:0] hm;
  logic [7:0] grp_new;
  logic [7:0] grp_old;
  logic       reflect;
  logic [1:0] size;
  logic       vdel;
  // Set at the start of every counter pass, cleared when the strobe fires, so a
  // pos moved ahead of the counter by HMOVE cannot produce a second strobe in the same pass.
  logic       armed;

  logic              counter_wrap;
  logic              fire;
  logic signed [8:0] hmove_sum;
  logic signed [8:0] hmove_adj;
  logic [7:0]        pos_moved;

  assign counter_wrap = pixel_tick && (counter == LAST_PIXEL);
  assign fire         = pixel_tick && (counter == pos) && armed;

  // pos - hm in 9-bit signed, folded back into 0..159
  always_comb begin
    hmove_sum = $signed({1'b0, pos}) - $signed({{5{hm[3]}}, hm});
    hmove_adj = hmove_sum;
    if (hmove_sum < 9'sd0) begin
      hmove_adj = hmove_sum + 9'sd160;
    end else if (hmove_sum >= 9'sd160) begin
      hmove_adj = hmove_sum - 9'sd160;
    end
    pos_moved = hmove_adj[7:0];
  end

  // Pixel counter: line_start wins over pixel_tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter <= 8'd0;
    end else if (line_start) begin
      counter <= 8'd0;
    end else if (pixel_tick) begin
      counter <= counter_wrap ? 8'd0 : counter + 8'd1;
    end
  end

  // CPU-visible registers; grp_old copy reads pre-edge grp_new so a GRP write
  // in the same clk lands only in grp_new
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos     <= 8'd0;
      hm      <= 4'd0;
      grp_new <= 8'd0;
      grp_old <= 8'd0;
      reflect <= 1'b0;
      size    <= 2'd0;
      vdel    <= 1'b0;
    end else begin
      if (grp_other_write) begin
        grp_old <= grp_new;
      end
      if (reg_write) begin
        case (reg_addr)
          A_GRP:   grp_new <= reg_data;
          A_REFP:  reflect <= reg_data[3];
          A_NUSIZ: size    <= reg_data[1:0];
          A_VDEL:  vdel    <= reg_data[0];
          A_HMP:   hm      <= reg_data[7:4];
          A_RESP:  pos     <= counter;
          A_HMOVE: pos     <= pos_moved;
          A_HMCLR: hm      <= 4'd0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed <= 1'b1;
    end else if (line_start || counter_wrap) begin
      armed <= 1'b1;
    end else if (fire) begin
      armed <= 1'b0;
    end
  end

  // Strobe and shadow latch use pre-edge register values, so a register write
  // in the strobe clk only shows up at the following strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe    <= 1'b0;
      data      <= 8'd0;
      width     <= 2'd0;
      direction <= 1'b0;
    end else begin
      strobe <= fire;
      if (fire) begin
        data      <= vdel ? grp_old : grp_new;
        width     <= size;
        direction <= reflect;
      end
    end
  end

endmodule

// File: tb/tb_player_position.sv
module tb_player_position;

  logic       clk;
  logic       reset_n;
  logic       line_start;
  logic       pixel_tick;
  logic       reg_write;
  logic [2:0] reg_addr;
  logic [7:0] reg_data;
  logic       grp_other_write;
  logic       strobe;
  logic [7:0] data;
  logic [1:0] width;
  logic       direction;

  int vectors;
  int miscompares;

  int         cnt;
  int         at;
  logic [7:0] cap_d;
  logic [1:0] cap_w;
  logic       cap_dir;

  player_position dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .line_start      (line_start),
    .pixel_tick      (pixel_tick),
    .reg_write       (reg_write),
    .reg_addr        (reg_addr),
    .reg_data        (reg_data),
    .grp_other_write (grp_other_write),
    .strobe          (strobe),
    .data            (data),
    .width           (width),
    .direction       (direction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one clk of inputs, then sample #1 after the edge and return inputs to idle.
  task automatic step(input logic ls, input logic pt, input logic wr,
                      input logic [2:0] a, input logic [7:0] d, input logic go);
    line_start      = ls;
    pixel_tick      = pt;
    reg_write       = wr;
    reg_addr        = a;
    reg_data        = d;
    grp_other_write = go;
    @(posedge clk);
    #1;
    line_start      = 1'b0;
    pixel_tick      = 1'b0;
    reg_write       = 1'b0;
    reg_addr        = 3'd0;
    reg_data        = 8'd0;
    grp_other_write = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
  endtask

  // line_start then one full pass of 160 ticks; counts strobes and captures
  // the shadow outputs plus the pre-edge counter value of the last strobe.
  task automatic run_line(output int n, output int where, output logic [7:0] d,
                          output logic [1:0] w, output logic dir);
    n = 0; where = -1; d = 8'hxx; w = 2'bxx; dir = 1'bx;
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    for (int i = 0; i < 160; i++) begin
      step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
      if (strobe === 1'b1) begin
        n++; where = i; d = data; w = width; dir = direction;
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0;
    line_start = 1'b0; pixel_tick = 1'b0; reg_write = 1'b0;
    reg_addr = 3'd0; reg_data = 8'd0; grp_other_write = 1'b0;
    #2;
    check("rst_strobe", 32'(strobe), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_width", 32'(width), 32'd0);
    check("rst_dir", 32'(direction), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("rst_counter", 32'(dut.counter), 32'd0);
    check("rst_pos", 32'(dut.pos), 32'd0);

    // RESP at counter 40, then one pass: a single strobe at counter 40
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    ticks(40);
    check("cnt_40", 32'(dut.counter), 32'd40);
    wr(3'd5, 8'h00);
    check("resp_pos40", 32'(dut.pos), 32'd40);
    check("resp_cnt_kept", 32'(dut.counter), 32'd40);
    run_line(cnt, at, cap_d, cap_w, cap_dir);
    check("line40_count", 32'(cnt), 32'd1);
    check("line40_at", 32'(at), 32'd40);
    check("wrap_to_0", 32'(dut.counter), 32'd0);

    // line_start wins over pixel_tick
    ticks(100);
    check("cnt_100", 32'(dut.counter), 32'd100);
    step(1'b1, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
    check("ls_prio", 32'(dut.counter), 32'd0);
    check("ls_keeps_pos", 32'(dut.pos), 32'd40);

    // HMOVE wrap both ways
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    ticks(155);
    wr(3'd5, 8'h00);
    check("pos_155", 32'(dut.pos), 32'd155);
    wr(3'd4, 8'h80);
    wr(3'd6, 8'h00);
    check("hmove_m8", 32'(dut.pos), 32'd3);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    ticks(2);
    wr(3'd5, 8'h00);
    wr(3'd4, 8'h70);
    wr(3'd6, 8'h00);
    check("hmove_p7", 32'(dut.pos), 32'd155);
    wr(3'd7, 8'h00);
    wr(3'd6, 8'h00);
    check("hmclr_move", 32'(dut.pos), 32'd155);

    // Vertical delay: grp_old stays 0 until the other player's GRP write
    wr(3'd0, 8'hA5);
    wr(3'd3, 8'h01);
    run_line(cnt, at, cap_d, cap_w, cap_dir);
    check("vdel_count", 32'(cnt), 32'd1);
    check("vdel_at", 32'(at), 32'd155);
    check("vdel_old0", 32'(cap_d), 32'h00);
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b1);
    run_line(cnt, at, cap_d, cap_w, cap_dir);
    check("vdel_copy", 32'(cap_d), 32'hA5);

    // Reflect / size / pattern latched at strobe
    wr(3'd3, 8'h00);
    wr(3'd1, 8'h08);
    wr(3'd2, 8'h01);
    wr(3'd0, 8'h3C);
    run_line(cnt, at, cap_d, cap_w, cap_dir);
    check("latch_dir", 32'(cap_dir), 32'd1);
    check("latch_width", 32'(cap_w), 32'd1);
    check("latch_data", 32'(cap_d), 32'h3C);

    // NUSIZ write in the strobe clk: width keeps the pre-write value
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    ticks(155);
    step(1'b0, 1'b1, 1'b1, 3'd2, 8'h02, 1'b0);
    check("same_clk_strobe", 32'(strobe), 32'd1);
    check("same_clk_width", 32'(width), 32'd1);
    ticks(4);
    check("strobe_one_clk", 32'(strobe), 32'd0);
    run_line(cnt, at, cap_d, cap_w, cap_dir);
    check("next_width", 32'(cap_w), 32'd2);

    // Simultaneous GRP write and grp_other_write
    step(1'b0, 1'b0, 1'b1, 3'd0, 8'h11, 1'b1);
    wr(3'd3, 8'h01);
    run_line(cnt, at, cap_d, cap_w, cap_dir);
    check("sim_grp_old", 32'(cap_d), 32'h3C);
    wr(3'd3, 8'h00);
    run_line(cnt, at, cap_d, cap_w, cap_dir);
    check("sim_grp_new", 32'(cap_d), 32'h11);

    // RESP in a tick clk: pos takes pre-increment counter, strobe uses old pos
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    ticks(10);
    step(1'b0, 1'b1, 1'b1, 3'd5, 8'h00, 1'b0);
    check("resp_tick_pos", 32'(dut.pos), 32'd10);
    check("resp_tick_cnt", 32'(dut.counter), 32'd11);
    check("resp_tick_nostb", 32'(strobe), 32'd0);

    // HMOVE (+1) in the matching tick clk: strobe from old pos, no second strobe
    wr(3'd4, 8'h10);
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    ticks(10);
    step(1'b0, 1'b1, 1'b1, 3'd6, 8'h00, 1'b0);
    check("hmove_tick_stb", 32'(strobe), 32'd1);
    check("hmove_tick_pos", 32'(dut.pos), 32'd9);
    cnt = 0;
    for (int i = 11; i < 160; i++) begin
      step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
      if (strobe === 1'b1) cnt++;
    end
    check("no_second_stb", 32'(cnt), 32'd0);

    // Reset mid-line with pos = counter+1
    step(1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    ticks(8);
    check("pre_rst_data", 32'(data), 32'h11);
    check("pre_rst_width", 32'(width), 32'd2);
    pixel_tick = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_strobe", 32'(strobe), 32'd0);
    check("arst_data", 32'(data), 32'd0);
    check("arst_width", 32'(width), 32'd0);
    check("arst_dir", 32'(direction), 32'd0);
    @(posedge clk); #1;
    check("in_rst_strobe", 32'(strobe), 32'd0);
    check("in_rst_cnt", 32'(dut.counter), 32'd0);
    check("in_rst_pos", 32'(dut.pos), 32'd0);
    pixel_tick = 1'b0;
    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0);
    check("post_rst_idle", 32'(strobe), 32'd0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0);
    check("post_rst_match", 32'(strobe), 32'd1);
    check("post_rst_data", 32'(data), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
